// File: rtl/corectrl_pkg.sv
// Core-wide ISA constants (eei) and decode control/entry types (corectrl).
// eei must compile before corectrl, so both packages live in this one file.
package eei;

    localparam int XLEN = 64;

    typedef logic [XLEN-1:0] UIntX;
    typedef logic [31:0]     Inst;
    typedef logic [6:0]      Opcode;

    localparam Opcode OP_LOAD     = 7'b0000011;
    localparam Opcode OP_MISC_MEM = 7'b0001111;
    localparam Opcode OP_IMM      = 7'b0010011;
    localparam Opcode OP_AUIPC    = 7'b0010111;
    localparam Opcode OP_IMM_32   = 7'b0011011;
    localparam Opcode OP_STORE    = 7'b0100011;
    localparam Opcode OP_OP       = 7'b0110011;
    localparam Opcode OP_LUI      = 7'b0110111;
    localparam Opcode OP_OP_32    = 7'b0111011;
    localparam Opcode OP_BRANCH   = 7'b1100011;
    localparam Opcode OP_JALR     = 7'b1100111;
    localparam Opcode OP_JAL      = 7'b1101111;
    localparam Opcode OP_SYSTEM   = 7'b1110011;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam Inst INST_ECALL  = 32'h0000_0073;
    localparam Inst INST_EBREAK = 32'h0010_0073;
    localparam Inst INST_MRET   = 32'h3020_0073;

endpackage

package corectrl;

    import eei::*;

    typedef enum logic [2:0] {
        INST_X,
        INST_R,
        INST_I,
        INST_S,
        INST_B,
        INST_U,
        INST_J
    } InstType;

    typedef struct packed {
        InstType    itype;
        logic       rwb_en;
        logic       is_lui;
        logic       is_aluop;
        logic       is_muldiv;
        logic       is_op32;
        logic       is_jump;
        logic       is_load;
        logic       is_csr;
        logic [2:0] funct3;
        logic [6:0] funct7;
    } InstCtrl;

    typedef struct packed {
        UIntX       addr;
        Inst        bits;
        InstCtrl    ctrl;
        UIntX       imm;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       illegal;
    } DecodedEntry;

endpackage

// File: rtl/decode_fifo.sv
// Circular queue of decoded entries; payload type and depth are parameters.
module decode_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic push_i,
    input  logic pop_i,
    input  T     wdata_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    T                 mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Flush wins over both sides of the handshake in the same cycle.
    assign push_ok = push_i && !full_o && !flush;
    assign pop_ok  = pop_i && !empty_o && !flush;

    assign rdata_o = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV64I + Zicsr decode stage feeding a small queue of decoded entries.
// Define M_EXT_EN to compile in RV64M (MUL/DIV) decode.
module decode_stage
    import eei::*;
    import corectrl::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = XLEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              i_valid,
    output logic              i_ready,
    input  logic [ADDR_W-1:0] i_addr,
    input  Inst               i_bits,
    output logic              o_valid,
    input  logic              o_ready,
    output DecodedEntry       o_entry
);

    Opcode       opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    InstCtrl     ctrl;
    logic        legal;
    UIntX        imm;
    DecodedEntry dec;
    logic        full;
    logic        empty;

    assign opcode = i_bits[6:0];
    assign f3     = i_bits[14:12];
    assign f7     = i_bits[31:25];

    always_comb begin
        ctrl        = '0;
        ctrl.itype  = INST_X;
        ctrl.funct3 = f3;
        ctrl.funct7 = f7;
        legal       = 1'b0;
        case (opcode)
            OP_LUI: begin
                ctrl.itype  = INST_U;
                ctrl.rwb_en = 1'b1;
                ctrl.is_lui = 1'b1;
                legal       = 1'b1;
            end
            OP_AUIPC: begin
                ctrl.itype  = INST_U;
                ctrl.rwb_en = 1'b1;
                legal       = 1'b1;
            end
            OP_JAL: begin
                ctrl.itype   = INST_J;
                ctrl.rwb_en  = 1'b1;
                ctrl.is_jump = 1'b1;
                legal        = 1'b1;
            end
            OP_JALR: begin
                ctrl.itype   = INST_I;
                ctrl.rwb_en  = 1'b1;
                ctrl.is_jump = 1'b1;
                legal        = (f3 == 3'b000);
            end
            OP_BRANCH: begin
                ctrl.itype = INST_B;
                legal      = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OP_LOAD: begin
                ctrl.itype   = INST_I;
                ctrl.rwb_en  = 1'b1;
                ctrl.is_load = 1'b1;
                legal        = (f3 != 3'b111);
            end
            OP_STORE: begin
                ctrl.itype = INST_S;
                legal      = !f3[2];
            end
            OP_IMM: begin
                ctrl.itype    = INST_I;
                ctrl.rwb_en   = 1'b1;
                ctrl.is_aluop = 1'b1;
                // 64-bit shifts use a 6-bit shamt, so only bits[31:26] carry funct.
                case (f3)
                    3'b001:  legal = (i_bits[31:26] == 6'b000000);
                    3'b101:  legal = (i_bits[31:26] == 6'b000000) || (i_bits[31:26] == 6'b010000);
                    default: legal = 1'b1;
                endcase
            end
            OP_IMM_32: begin
                ctrl.itype    = INST_I;
                ctrl.rwb_en   = 1'b1;
                ctrl.is_aluop = 1'b1;
                ctrl.is_op32  = 1'b1;
                case (f3)
                    3'b000:  legal = 1'b1;
                    3'b001:  legal = (f7 == F7_BASE);
                    3'b101:  legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                    default: legal = 1'b0;
                endcase
            end
            OP_OP: begin
                ctrl.itype  = INST_R;
                ctrl.rwb_en = 1'b1;
                if (f7 == F7_BASE) begin
                    ctrl.is_aluop = 1'b1;
                    legal         = 1'b1;
                end else if (f7 == F7_ALT) begin
                    ctrl.is_aluop = 1'b1;
                    legal         = (f3 == 3'b000) || (f3 == 3'b101);
                end
`ifdef M_EXT_EN
                else if (f7 == F7_MULDIV) begin
                    ctrl.is_muldiv = 1'b1;
                    legal          = 1'b1;
                end
`endif
            end
            OP_OP_32: begin
                ctrl.itype   = INST_R;
                ctrl.rwb_en  = 1'b1;
                ctrl.is_op32 = 1'b1;
                if (f7 == F7_BASE) begin
                    ctrl.is_aluop = 1'b1;
                    legal         = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);
                end else if (f7 == F7_ALT) begin
                    ctrl.is_aluop = 1'b1;
                    legal         = (f3 == 3'b000) || (f3 == 3'b101);
                end
`ifdef M_EXT_EN
                else if (f7 == F7_MULDIV) begin
                    ctrl.is_muldiv = 1'b1;
                    legal          = (f3 == 3'b000) || f3[2];
                end
`endif
            end
            OP_MISC_MEM: begin
                ctrl.itype = INST_I;
                legal      = (f3 == 3'b000);
            end
            OP_SYSTEM: begin
                if (f3 == 3'b000) begin
                    ctrl.itype = INST_X;
                    legal      = (i_bits == INST_ECALL) || (i_bits == INST_EBREAK)
                              || (i_bits == INST_MRET);
                end else begin
                    ctrl.itype  = INST_I;
                    ctrl.rwb_en = 1'b1;
                    ctrl.is_csr = 1'b1;
                    legal       = (f3 != 3'b100);
                end
            end
            default: legal = 1'b0;
        endcase
        // Illegal encodings travel down the pipe but must not write or redirect.
        if (!legal) begin
            ctrl        = '0;
            ctrl.itype  = INST_X;
            ctrl.funct3 = f3;
            ctrl.funct7 = f7;
        end
    end

    always_comb begin
        imm = '0;
        case (ctrl.itype)
            INST_I:  imm = {{(XLEN-12){i_bits[31]}}, i_bits[31:20]};
            INST_S:  imm = {{(XLEN-12){i_bits[31]}}, i_bits[31:25], i_bits[11:7]};
            INST_B:  imm = {{(XLEN-13){i_bits[31]}}, i_bits[31], i_bits[7],
                            i_bits[30:25], i_bits[11:8], 1'b0};
            INST_U:  imm = {{(XLEN-32){i_bits[31]}}, i_bits[31:12], 12'h000};
            INST_J:  imm = {{(XLEN-21){i_bits[31]}}, i_bits[31], i_bits[19:12],
                            i_bits[20], i_bits[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.addr    = UIntX'(i_addr);
        dec.bits    = i_bits;
        dec.ctrl    = ctrl;
        dec.imm     = imm;
        dec.rs1     = i_bits[19:15];
        dec.rs2     = i_bits[24:20];
        dec.rd      = ctrl.rwb_en ? i_bits[11:7] : 5'd0;
        dec.illegal = !legal;
    end

    // Handshake: a transfer happens on a rising edge where valid && ready on that side;
    // i_ready depends only on queue fullness (never on o_ready), and o_entry holds
    // steady while o_valid && !o_ready.
    assign i_ready = !full;
    assign o_valid = !empty;

    decode_fifo #(
        .DEPTH(DEPTH),
        .T    (DecodedEntry)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .push_i (i_valid),
        .pop_i  (o_ready),
        .wdata_i(dec),
        .rdata_o(o_entry),
        .full_o (full),
        .empty_o(empty)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode results, queue handshake, flush and async reset.
module tb_decode_stage;

    import eei::*;
    import corectrl::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        i_valid;
    logic        i_ready;
    logic [63:0] i_addr;
    logic [31:0] i_bits;
    logic        o_valid;
    logic        o_ready;
    DecodedEntry o_entry;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] ADDI  = 32'h0050_0093;
    localparam logic [31:0] MUL   = 32'h0220_8033;
    localparam logic [31:0] ONES  = 32'hFFFF_FFFF;
    localparam logic [31:0] CSRRW = 32'h3000_91F3;
    localparam logic [31:0] MRET  = 32'h3020_0073;
    localparam logic [31:0] LUI   = 32'h1234_52B7;
    localparam logic [31:0] SW    = 32'h0020_A423;
    localparam logic [31:0] BEQ   = 32'hFE00_0EE3;
    localparam logic [31:0] JAL   = 32'h0100_00EF;

    decode_stage dut (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .i_valid(i_valid),
        .i_ready(i_ready),
        .i_addr (i_addr),
        .i_bits (i_bits),
        .o_valid(o_valid),
        .o_ready(o_ready),
        .o_entry(o_entry)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] bits, input logic [63:0] addr);
        i_valid = 1'b1;
        i_bits  = bits;
        i_addr  = addr;
        step();
        i_valid = 1'b0;
    endtask

    task automatic pop();
        o_ready = 1'b1;
        step();
        o_ready = 1'b0;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        flush   = 1'b0;
        i_valid = 1'b0;
        i_addr  = '0;
        i_bits  = '0;
        o_ready = 1'b0;
        #2;
        check("rst_o_valid", 64'(o_valid), 64'd0);
        check("rst_i_ready", 64'(i_ready), 64'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // ADDI x1,x0,5 with one-cycle latency
        push(ADDI, 64'h1000);
        check("addi_valid",   64'(o_valid), 64'd1);
        check("addi_itype",   64'(o_entry.ctrl.itype), 64'(INST_I));
        check("addi_imm",     o_entry.imm, 64'd5);
        check("addi_rd",      64'(o_entry.rd), 64'd1);
        check("addi_rwb",     64'(o_entry.ctrl.rwb_en), 64'd1);
        check("addi_illegal", 64'(o_entry.illegal), 64'd0);
        check("addi_addr",    o_entry.addr, 64'h1000);
        pop();
        check("addi_drained", 64'(o_valid), 64'd0);

        // MUL x0,x1,x2 depends on the M build option
        push(MUL, 64'h1004);
        check("mul_valid", 64'(o_valid), 64'd1);
`ifdef M_EXT_EN
        check("mul_illegal", 64'(o_entry.illegal), 64'd0);
        check("mul_muldiv",  64'(o_entry.ctrl.is_muldiv), 64'd1);
`else
        check("mul_illegal", 64'(o_entry.illegal), 64'd1);
        check("mul_muldiv",  64'(o_entry.ctrl.is_muldiv), 64'd0);
`endif
        check("mul_rd", 64'(o_entry.rd), 64'd0);
        pop();

        // all-ones word is illegal but still enqueued
        push(ONES, 64'h1008);
        check("ones_valid",   64'(o_valid), 64'd1);
        check("ones_illegal", 64'(o_entry.illegal), 64'd1);
        check("ones_rwb",     64'(o_entry.ctrl.rwb_en), 64'd0);
        check("ones_rd",      64'(o_entry.rd), 64'd0);
        pop();

        // CSRRW x3, 0x300, x1 and MRET
        push(CSRRW, 64'h100C);
        check("csr_is_csr",  64'(o_entry.ctrl.is_csr), 64'd1);
        check("csr_rd",      64'(o_entry.rd), 64'd3);
        check("csr_imm",     o_entry.imm, 64'h300);
        check("csr_rs1",     64'(o_entry.rs1), 64'd1);
        check("csr_illegal", 64'(o_entry.illegal), 64'd0);
        pop();
        push(MRET, 64'h1010);
        check("mret_illegal", 64'(o_entry.illegal), 64'd0);
        check("mret_rwb",     64'(o_entry.ctrl.rwb_en), 64'd0);
        pop();

        // fill DEPTH=2 with o_ready low, third push held
        exp_q = {LUI, SW, BEQ};
        i_valid = 1'b1;
        i_bits  = LUI;
        i_addr  = 64'h2000;
        step();
        check("fill1_ready", 64'(i_ready), 64'd1);
        i_bits = SW;
        i_addr = 64'h2004;
        step();
        check("fill2_ready", 64'(i_ready), 64'd0);
        i_bits = BEQ;
        i_addr = 64'h2008;
        step();
        check("held_ready", 64'(i_ready), 64'd0);
        check("head_a_bits", 64'(o_entry.bits), 64'(exp_q.pop_front()));
        check("head_a_imm",  o_entry.imm, 64'h0000_0000_1234_5000);
        check("head_a_lui",  64'(o_entry.ctrl.is_lui), 64'd1);
        o_ready = 1'b1;
        step();
        check("head_b_valid", 64'(o_valid), 64'd1);
        check("head_b_bits",  64'(o_entry.bits), 64'(exp_q.pop_front()));
        check("head_b_imm",   o_entry.imm, 64'd8);
        check("head_b_rd",    64'(o_entry.rd), 64'd0);
        check("head_b_ready", 64'(i_ready), 64'd1);
        step();
        i_valid = 1'b0;
        check("head_c_valid", 64'(o_valid), 64'd1);
        check("head_c_bits",  64'(o_entry.bits), 64'(exp_q.pop_front()));
        check("head_c_imm",   o_entry.imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("head_c_itype", 64'(o_entry.ctrl.itype), 64'(INST_B));
        check("head_c_addr",  o_entry.addr, 64'h2008);
        check("simul_ready",  64'(i_ready), 64'd1);
        step();
        o_ready = 1'b0;
        check("abc_drained", 64'(o_valid), 64'd0);

        // flush a full queue with an incoming entry
        push(ADDI, 64'h4000);
        push(SW, 64'h4004);
        check("pre_flush_full", 64'(i_ready), 64'd0);
        flush   = 1'b1;
        i_valid = 1'b1;
        i_bits  = JAL;
        step();
        flush   = 1'b0;
        i_valid = 1'b0;
        check("flush_valid", 64'(o_valid), 64'd0);
        check("flush_ready", 64'(i_ready), 64'd1);
        step();
        check("flush_no_incoming", 64'(o_valid), 64'd0);

        // flush overrides a same-cycle enqueue and dequeue
        push(ADDI, 64'h4010);
        flush   = 1'b1;
        i_valid = 1'b1;
        o_ready = 1'b1;
        i_bits  = JAL;
        step();
        flush   = 1'b0;
        i_valid = 1'b0;
        o_ready = 1'b0;
        check("flush_pushpop_valid", 64'(o_valid), 64'd0);

        // asynchronous reset mid-cycle
        push(ADDI, 64'h5000);
        check("pre_rst_valid", 64'(o_valid), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(o_valid), 64'd0);
        check("async_rst_ready", 64'(i_ready), 64'd1);
        #1;
        rst = 1'b0;
        push(JAL, 64'h6000);
        check("post_rst_valid", 64'(o_valid), 64'd1);
        check("post_rst_bits",  64'(o_entry.bits), 64'(JAL));
        check("post_rst_imm",   o_entry.imm, 64'd16);
        check("post_rst_jump",  64'(o_entry.ctrl.is_jump), 64'd1);
        check("post_rst_rd",    64'(o_entry.rd), 64'd1);
        pop();
        check("final_empty", 64'(o_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DEPTH, default 2, decoded-entry queue depth (power of 2, >=2).
REQ-002 SHALL have parameter ADDR_W, default XLEN, instruction address width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard all queued and incoming entries.
REQ-006 SHALL have port i_valid  input  1  fetch entry present.
REQ-007 SHALL have port i_ready  output  1  stage accepts entry this cycle.
REQ-008 SHALL have port i_addr  input  ADDR_W  instruction address.
REQ-009 SHALL have port i_bits  input  32  instruction word (Inst).
REQ-010 SHALL have port o_valid  output  1  head entry present.
REQ-011 SHALL have port o_ready  input  1  consumer takes head entry.
REQ-012 SHALL have port o_entry  output  DecodedEntry  head: addr, bits, ctrl (InstCtrl), imm (UIntX), rs1, rs2, rd, illegal.

Function
REQ-013 SHALL decode i_bits combinationally: itype, rwb_en, is_lui, is_aluop, is_muldiv, is_op32, is_jump, is_load, is_csr, funct3, funct7, sign-extended I/S/B/U/J immediate to XLEN.
REQ-014 SHALL set illegal=1 for any encoding outside RV64I + Zicsr + ECALL/EBREAK/MRET + FENCE (plus M per REQ-030); illegal entries are still enqueued, with all ctrl write/branch flags 0.
REQ-015 SHALL extract rd=bits[11:7], rs1=bits[19:15], rs2=bits[24:20]; rd forced to 0 when rwb_en=0.
REQ-016 SHALL drive imm=0 for itypes without an immediate (R, X).
REQ-017 SHALL enqueue on i_valid && i_ready; i_ready = !full, independent of o_ready (no full-queue bypass).
REQ-018 SHALL dequeue on o_valid && o_ready; o_valid = !empty; o_entry stable while o_valid && !o_ready.
REQ-019 SHALL have latency 1 cycle: entry accepted at edge N appears on o_entry after edge N when queue was empty.
REQ-020 SHALL support simultaneous enqueue and dequeue when neither full nor empty; count unchanged, order preserved.
REQ-021 SHALL keep read/write pointers of $clog2(DEPTH) bits with natural wrap-around, count $clog2(DEPTH)+1 bits.
REQ-022 SHALL, on flush, empty the queue at the next edge; flush overrides a same-cycle enqueue and dequeue (both dropped).
REQ-023 SHALL never overflow or underflow: enqueue while full and dequeue while empty are ignored.

Reset
REQ-024 SHALL, on rst asserted, asynchronously clear pointers and count: o_valid=0, i_ready=1.
REQ-025 SHALL discard in-flight entries on reset mid-operation; queue payload storage need not be reset.
REQ-026 SHALL drive o_entry as don't-care while o_valid=0; benches check o_entry only when o_valid=1.

Configuration
REQ-027 SHALL use macro M_EXT_EN to compile in RV64M decode.
REQ-028 With M_EXT_EN: OP funct7=0000001 all funct3 legal, is_muldiv=1; OP_32 funct7=0000001 legal for funct3 000,100,101,110,111.
REQ-029 Without M_EXT_EN: every funct7=0000001 OP/OP_32 encoding illegal=1, is_muldiv constant 0.
REQ-030 SHALL leave all other decode identical in both builds.

Structure
REQ-031 SHALL add DecodedEntry struct to package corectrl; opcodes, InstType, InstCtrl, XLEN, UIntX, Inst stay in eei/corectrl.
REQ-032 SHALL place queue storage in one sub-module decode_fifo (DEPTH, payload type); decode logic in decode_stage.

Verification
REQ-033 i_bits=0x00500093 (ADDI x1,x0,5), queue empty -> next cycle o_valid=1, itype=INST_I, imm=5, rd=1, rwb_en=1, illegal=0.
REQ-034 i_bits=0x02208033 (MUL x0,x1,x2) -> with M_EXT_EN is_muldiv=1, illegal=0, rd=0; without: illegal=1, is_muldiv=0.
REQ-035 DEPTH=2, o_ready=0, 3 consecutive valid pushes -> i_ready=0 after 2nd accept, 3rd held; o_ready=1 -> entries pop in order A,B,C.
REQ-036 Queue holding 2 entries, flush=1 with i_valid=1 -> next cycle o_valid=0, i_ready=1, incoming entry absent.
REQ-037 i_bits=0xFFFFFFFF -> enqueued with illegal=1, rwb_en=0, rd=0.
REQ-038 rst pulsed mid-stream, asynchronous to clk -> o_valid=0 immediately, i_ready=1; first post-reset push appears after 1 cycle.
